// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state encoding, default oversampling/stop-tick values, parity mode.
package uart_pkg;

  // Receiver FSM encoding; ST_PARITY is only reachable when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_OS      = 16;
  localparam int DEF_SB_TICK = 16;

  // 0 selects even parity: the parity bit makes the total count of ones even.
  localparam logic PARITY_ODD = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clocks from i_d to o_q. Backpressure: none (free-running).
// Ports: i_clk, i_reset_n (synchronous, active low), i_d (async in), o_q (synced out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive FSM: start validation, mid-bit sampling, optional even parity, stop check.
// Latency: rx_done_tick one clock after the s_tick ending the stop bit. Backpressure: none; result held until next frame.
// Ports: clk, reset (sync active low), rx, s_tick in; dout, rx_done_tick, frame_err, parity_err out.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int OS      = DEF_OS,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  // Tick counter must hold max(OS, SB_TICK) - 1; bit counter must hold DBIT - 1.
  localparam int SW = ($clog2(max_int(OS, SB_TICK)) > 0) ? $clog2(max_int(OS, SB_TICK)) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_START_END = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT_END   = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic            w_rx_s;
  logic [DBIT:0]   w_b_cat;
  logic [DBIT-1:0] w_b_next;

  rx_state_t       r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic            r_par_mis;
  logic            r_parity_err;
`endif

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_d       (rx),
    .o_q       (w_rx_s)
  );

  // LSB-first shift: new bit enters at the MSB and everything moves down one place.
  assign w_b_cat  = {w_rx_s, r_b};
  assign w_b_next = w_b_cat[DBIT:1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mis    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // Ticks are ignored here, so a tick coincident with the return to IDLE is dropped.
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_s     <= '0;
          end
        end

        // Recheck the line half a bit in; a high level means the falling edge was a glitch.
        ST_START: begin
          if (s_tick) begin
            if (r_s == S_START_END) begin
              if (!w_rx_s) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        // From the start-bit midpoint, every OS ticks lands in the middle of the next bit.
        ST_DATA: begin
          if (s_tick) begin
            if (r_s == S_BIT_END) begin
              r_s <= '0;
              r_b <= w_b_next;
              if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (r_s == S_BIT_END) begin
              r_par_mis <= w_rx_s ^ (^r_b) ^ PARITY_ODD;
              r_s       <= '0;
              r_state   <= ST_STOP;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
`endif

        ST_STOP: begin
          if (s_tick) begin
            if (r_s == S_STOP_END) begin
              r_dout      <= r_b;
              r_frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_mis;
`endif
              r_done      <= 1'b1;
              r_s         <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_parity_err;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
